// File: rtl/algo_centroid_if.sv
`default_nettype none
// ============================================================================
// Module   : algo_centroid_if
// Purpose  : 32-bit Avalon-ST style streaming bundle used on both sides of
//            the centroid stage.
// Ports    : data[31:0], valid, ready, empty[1:0], startofpacket,
//            endofpacket
//            master = source side, slave = sink side
// Revision : 1.0  initial release
// ============================================================================
interface algo_centroid_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [1:0]  empty;
    logic        startofpacket;
    logic        endofpacket;

    modport master (
        output data, valid, empty, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, empty, startofpacket, endofpacket,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/algo_centroid.sv
`default_nettype none
// ============================================================================
// Module   : algo_centroid
// Purpose  : Consumes one sensor packet (header, 2-channel data words,
//            trailer) and emits a result packet holding the header, channel
//            sum, index-weighted sum, peak channel/value, trailer and status.
// Ports    : clk_clk    - clock
//            rst_reset  - synchronous active-high reset
//            data_in    - sensor packet sink   (slave modport)
//            data_out   - result packet source (master modport)
// Revision : 1.0  initial release
// ============================================================================
module algo_centroid #(
    parameter int HEADER_WORDS  = 3,
    parameter int DATA_WORDS    = 159,
    parameter int TRAILER_WORDS = 1,
    parameter int CLAMP_NEG     = 1
) (
    input  logic            clk_clk,
    input  logic            rst_reset,
    algo_centroid_if.slave  data_in,
    algo_centroid_if.master data_out
);

    localparam int c_out_words = HEADER_WORDS + 6;
    localparam int c_tx_w      = $clog2(c_out_words);
    localparam logic [15:0] c_data_start = 16'(HEADER_WORDS);
    localparam logic [15:0] c_data_end   = 16'(HEADER_WORDS + DATA_WORDS);
    localparam logic [15:0] c_trail_last = 16'(HEADER_WORDS + DATA_WORDS + TRAILER_WORDS - 1);
    localparam logic [16:0] c_total      = 17'(HEADER_WORDS + DATA_WORDS + TRAILER_WORDS);
    localparam logic [c_tx_w-1:0] c_tx_last = c_tx_w'(c_out_words - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RX     = 2'd1,
        S_FINISH = 2'd2,
        S_TX     = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]       r_hdr [HEADER_WORDS];
    logic [31:0]       r_res [c_out_words];
    logic [31:0]       r_sum, r_trailer;
    logic [39:0]       r_wsum;
    logic [15:0]       r_peak_val, r_peak_idx, r_rx_ctr, r_pkt_cnt;
    logic [c_tx_w-1:0] r_tx_ctr;
    logic              r_short, r_long, r_restart, r_clamp;

    logic        w_in_ready, w_out_valid, w_take, w_out_fire, w_is_data;
    logic [15:0] w_idx, w_ch, w_hi, w_lo;
    logic [16:0] w_cnt;
    logic [31:0] w_p_hi, w_p_lo, w_sum_nxt, w_out_word;
    logic [39:0] w_wsum_nxt;
    logic [15:0] w_peak_val_nxt, w_peak_idx_nxt;
    logic        w_clamp_nxt;
    logic        w_unused;

    assign w_unused   = ^data_in.empty;
    assign w_in_ready = (r_state == S_IDLE) || (r_state == S_RX);
    // In IDLE only an SOP beat starts a packet; anything else is swallowed.
    assign w_take     = data_in.valid && w_in_ready &&
                        ((r_state == S_RX) || data_in.startofpacket);
    assign w_out_fire = w_out_valid && data_out.ready;

    // Per-beat datapath: an SOP beat restarts from word 0 with cleared
    // accumulators, so the "base" values are zero in that case.
    always_comb begin
        w_idx          = data_in.startofpacket ? 16'd0 : r_rx_ctr;
        w_cnt          = {1'b0, w_idx} + 17'd1;
        w_is_data      = (w_idx >= c_data_start) && (w_idx < c_data_end);
        w_ch           = 16'((w_idx - c_data_start) << 1);
        w_hi           = data_in.data[31:16];
        w_lo           = data_in.data[15:0];
        w_clamp_nxt    = data_in.startofpacket ? 1'b0 : r_clamp;
        if (CLAMP_NEG != 0 && w_is_data) begin
            if (w_hi[15]) begin
                w_hi        = 16'd0;
                w_clamp_nxt = 1'b1;
            end
            if (w_lo[15]) begin
                w_lo        = 16'd0;
                w_clamp_nxt = 1'b1;
            end
        end
        w_p_hi         = {16'd0, w_ch} * {16'd0, w_hi};
        w_p_lo         = {16'd0, w_ch + 16'd1} * {16'd0, w_lo};
        w_sum_nxt      = data_in.startofpacket ? 32'd0 : r_sum;
        w_wsum_nxt     = data_in.startofpacket ? 40'd0 : r_wsum;
        w_peak_val_nxt = data_in.startofpacket ? 16'd0 : r_peak_val;
        w_peak_idx_nxt = data_in.startofpacket ? 16'd0 : r_peak_idx;
        if (w_is_data) begin
            w_sum_nxt  = w_sum_nxt + {16'd0, w_hi} + {16'd0, w_lo};
            w_wsum_nxt = w_wsum_nxt + {8'd0, w_p_hi} + {8'd0, w_p_lo};
            // hi wins within a word on a tie; across words strict '>' keeps
            // the lowest channel.
            if (w_hi >= w_lo) begin
                if (w_hi > w_peak_val_nxt) begin
                    w_peak_val_nxt = w_hi;
                    w_peak_idx_nxt = w_ch;
                end
            end else if (w_lo > w_peak_val_nxt) begin
                w_peak_val_nxt = w_lo;
                w_peak_idx_nxt = w_ch + 16'd1;
            end
        end
    end

    always_comb begin
        w_out_word = 32'd0;
        for (int i = 0; i < c_out_words; i++) begin
            if (r_tx_ctr == c_tx_w'(i)) w_out_word = r_res[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (rst_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:   if (w_take) w_state_nxt = data_in.endofpacket ? S_FINISH : S_RX;
            S_RX:     if (w_take && data_in.endofpacket) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_TX;
            S_TX: begin
                w_out_valid = 1'b1;
                if (w_out_fire && r_tx_ctr == c_tx_last) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            for (int i = 0; i < HEADER_WORDS; i++) r_hdr[i] <= 32'd0;
            for (int i = 0; i < c_out_words; i++)  r_res[i] <= 32'd0;
            r_sum      <= 32'd0;
            r_wsum     <= 40'd0;
            r_trailer  <= 32'd0;
            r_peak_val <= 16'd0;
            r_peak_idx <= 16'd0;
            r_rx_ctr   <= 16'd0;
            r_tx_ctr   <= '0;
            r_pkt_cnt  <= 16'd0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_restart  <= 1'b0;
            r_clamp    <= 1'b0;
        end else begin
            if (w_take) begin
                r_sum      <= w_sum_nxt;
                r_wsum     <= w_wsum_nxt;
                r_peak_val <= w_peak_val_nxt;
                r_peak_idx <= w_peak_idx_nxt;
                r_clamp    <= w_clamp_nxt;
                // Counter saturates so oversized packets still read as long.
                r_rx_ctr   <= w_cnt[16] ? 16'hFFFF : w_cnt[15:0];
                for (int i = 0; i < HEADER_WORDS; i++) begin
                    if (data_in.startofpacket) r_hdr[i] <= 32'd0;
                    if (w_idx == 16'(i))       r_hdr[i] <= data_in.data;
                end
                if (data_in.startofpacket) begin
                    r_trailer <= 32'd0;
                    r_short   <= 1'b0;
                    r_long    <= 1'b0;
                    r_restart <= (r_state == S_RX);
                end
                if (TRAILER_WORDS > 0 && w_idx == c_trail_last) r_trailer <= data_in.data;
                if (data_in.endofpacket) begin
                    r_short <= (w_cnt < c_total);
                    r_long  <= (w_cnt > c_total);
                end
            end
            if (r_state == S_FINISH) begin
                for (int i = 0; i < HEADER_WORDS; i++) r_res[i] <= r_hdr[i];
                r_res[HEADER_WORDS]     <= r_sum;
                r_res[HEADER_WORDS + 1] <= {24'd0, r_wsum[39:32]};
                r_res[HEADER_WORDS + 2] <= r_wsum[31:0];
                r_res[HEADER_WORDS + 3] <= {r_peak_idx, r_peak_val};
                r_res[HEADER_WORDS + 4] <= r_trailer;
                r_res[HEADER_WORDS + 5] <= {12'd0, r_clamp, r_restart, r_long, r_short, r_pkt_cnt};
                r_tx_ctr                <= '0;
            end
            if (w_out_fire) begin
                if (r_tx_ctr == c_tx_last) begin
                    r_tx_ctr  <= '0;
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                end else begin
                    r_tx_ctr  <= r_tx_ctr + 1'b1;
                end
            end
        end
    end

    assign data_in.ready           = w_in_ready;
    assign data_out.valid          = w_out_valid;
    assign data_out.data           = w_out_valid ? w_out_word : 32'd0;
    assign data_out.startofpacket  = w_out_valid && (r_tx_ctr == '0);
    assign data_out.endofpacket    = w_out_valid && (r_tx_ctr == c_tx_last);
    assign data_out.empty          = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_algo_centroid.sv
`default_nettype none
// ============================================================================
// Module   : tb_algo_centroid
// Purpose  : Self-checking bench for algo_centroid: directed and random
//            packets against a channel-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_algo_centroid;
    localparam int H   = 3;
    localparam int D   = 159;
    localparam int T   = 1;
    localparam int TOT = H + D + T;
    localparam int OW  = H + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    algo_centroid_if in_if ();
    algo_centroid_if out_if ();

    algo_centroid #(
        .HEADER_WORDS (H),
        .DATA_WORDS   (D),
        .TRAILER_WORDS(T),
        .CLAMP_NEG    (1)
    ) dut (
        .clk_clk  (clk),
        .rst_reset(rst),
        .data_in  (in_if.slave),
        .data_out (out_if.master)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          pkts = 0;
    int          sop_at2 = -1;
    logic [31:0] stim [$];
    logic [31:0] expw [OW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: expand the packet (from its last SOP) into a channel array,
    // then derive every result field with plain arithmetic.
    task automatic build_expected();
        logic [31:0] p [$];
        int unsigned ch [2*D];
        int unsigned v, pv;
        longint      s, ws;
        int          pi, n, start;
        bit          clamp;
        start = (sop_at2 >= 0) ? sop_at2 : 0;
        for (int i = start; i < stim.size(); i++) p.push_back(stim[i]);
        n = p.size();
        clamp = 0;
        foreach (ch[i]) ch[i] = 0;
        for (int k = 0; k < D; k++) begin
            if (H + k < n) begin
                for (int j = 0; j < 2; j++) begin
                    v = (j == 0) ? {16'd0, p[H+k][31:16]} : {16'd0, p[H+k][15:0]};
                    if (v >= 32768) begin
                        v = 0;
                        clamp = 1;
                    end
                    ch[2*k+j] = v;
                end
            end
        end
        s = 0; ws = 0; pv = 0; pi = 0;
        for (int c = 0; c < 2*D; c++) begin
            s  += ch[c];
            ws += longint'(c) * ch[c];
            if (ch[c] > pv) begin
                pv = ch[c];
                pi = c;
            end
        end
        for (int i = 0; i < H; i++) expw[i] = (i < n) ? p[i] : 32'd0;
        expw[H]   = s[31:0];
        expw[H+1] = {24'd0, ws[39:32]};
        expw[H+2] = ws[31:0];
        expw[H+3] = {pi[15:0], pv[15:0]};
        expw[H+4] = (TOT - 1 < n) ? p[TOT-1] : 32'd0;
        expw[H+5] = {12'd0, clamp, (sop_at2 >= 0), (n > TOT), (n < TOT), pkts[15:0]};
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop);
        int t;
        t = 0;
        @(negedge clk);
        in_if.data = d;
        in_if.valid = 1'b1;
        in_if.startofpacket = sop;
        in_if.endofpacket = eop;
        while (!in_if.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_if.ready) check("in_ready_timeout", {31'd0, in_if.ready}, 32'd1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready toggles every cycle.
    // abort_at >= 0: pulse reset while that beat index is presented.
    task automatic recv(input int mode, input int abort_at);
        int          n, cyc;
        bit          stalled;
        logic [31:0] held;
        n = 0; cyc = 0; stalled = 0; held = 0;
        while (n < OW && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) check("lat_finish_valid", {31'd0, out_if.valid}, 32'd0);
            if (cyc == 1) check("lat_tx_valid", {31'd0, out_if.valid}, 32'd1);
            if (abort_at >= 0 && n == abort_at && out_if.valid) begin
                out_if.ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
                check("rst_out_data", out_if.data, 32'd0);
                check("rst_out_sopeop", {30'd0, out_if.startofpacket, out_if.endofpacket}, 32'd0);
                check("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
                return;
            end
            out_if.ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (out_if.valid) begin
                check("in_ready_during_tx", {31'd0, in_if.ready}, 32'd0);
                if (stalled) check("stall_hold", out_if.data, held);
                if (out_if.ready) begin
                    check($sformatf("beat%0d_data", n), out_if.data, expw[n]);
                    check($sformatf("beat%0d_sopeop", n),
                          {30'd0, out_if.startofpacket, out_if.endofpacket},
                          {30'd0, (n == 0), (n == OW - 1)});
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = out_if.data;
                end
            end
            cyc++;
        end
        if (n < OW) check("recv_timeout_beats", n, OW);
        @(negedge clk);
        check("post_valid", {31'd0, out_if.valid}, 32'd0);
        check("post_in_ready", {31'd0, in_if.ready}, 32'd1);
        out_if.ready = 1'b0;
    endtask

    task automatic run_pkt(input int mode, input int abort_at);
        int last;
        build_expected();
        last = stim.size() - 1;
        for (int i = 0; i <= last; i++)
            send_beat(stim[i], (i == 0) || (i == sop_at2), (i == last));
        recv(mode, abort_at);
        if (abort_at < 0) pkts = (pkts + 1) & 16'hFFFF;
        else              pkts = 0;
    endtask

    function automatic logic [31:0] rnd_word();
        return $urandom & 32'h83FF83FF;
    endfunction

    task automatic fill_random(input int nwords);
        stim.delete();
        for (int i = 0; i < nwords; i++) stim.push_back(rnd_word());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.data = 32'd0;
        in_if.valid = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
        in_if.empty = 2'd0;
        out_if.ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_if.valid}, 32'd0);
        check("reset_out_data", out_if.data, 32'd0);
        check("reset_out_sopeop", {30'd0, out_if.startofpacket, out_if.endofpacket}, 32'd0);
        check("reset_out_empty", {30'd0, out_if.empty}, 32'd0);
        check("reset_in_ready", {31'd0, in_if.ready}, 32'd1);

        // Beats without SOP in IDLE are discarded.
        send_beat(32'hDEAD0001, 1'b0, 1'b0);
        send_beat(32'hDEAD0002, 1'b0, 1'b1);

        // Nominal packet
        stim.delete();
        stim.push_back(32'hA1); stim.push_back(32'hA2); stim.push_back(32'hA3);
        for (int k = 0; k < D; k++) stim.push_back(32'h00010001);
        stim.push_back(32'h1234);
        sop_at2 = -1;
        run_pkt(0, -1);

        // Single hit on channel 21
        stim.delete();
        stim.push_back(32'h11); stim.push_back(32'h22); stim.push_back(32'h33);
        for (int k = 0; k < D; k++) stim.push_back((k == 10) ? 32'h00000500 : 32'd0);
        stim.push_back(32'hCAFE);
        run_pkt(0, -1);

        // Negative clamp
        stim.delete();
        stim.push_back(32'h1); stim.push_back(32'h2); stim.push_back(32'h3);
        for (int k = 0; k < D; k++) stim.push_back((k == 0) ? 32'hFFFF0003 : 32'd0);
        stim.push_back(32'h5);
        run_pkt(0, -1);

        // Random packet under output backpressure
        fill_random(TOT);
        run_pkt(1, -1);

        // Short, long and restarted packets
        fill_random(100);
        run_pkt(0, -1);
        fill_random(170);
        run_pkt(1, -1);
        fill_random(50 + TOT);
        sop_at2 = 50;
        run_pkt(0, -1);
        sop_at2 = -1;

        // Reset during output beat 4, then a normal packet
        fill_random(TOT);
        run_pkt(0, 4);
        fill_random(TOT);
        run_pkt(0, -1);
        fill_random(TOT);
        run_pkt(1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
